// File: rtl/seg_pkg.sv
// Shared definitions for seven-segment display blocks: segment bit order,
// hex font and the scan slot state encoding.
package seg_pkg;

   localparam int unsigned SEG_W  = 8;
   localparam int unsigned FONT_W = 7;

   // Segment bit positions within {dp,g,f,e,d,c,b,a}
   localparam int unsigned SEG_A  = 0;
   localparam int unsigned SEG_G  = 6;
   localparam int unsigned SEG_DP = 7;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_DRIVE = 1'b1
   } slot_state_e;

   // Active-high {g..a} patterns, index 15 leftmost
   localparam logic [15:0][FONT_W-1:0] HEX_FONT = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   function automatic logic [FONT_W-1:0] hex_font(input logic [3:0] nib);
      return HEX_FONT[nib];
   endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Configuration and handshake bundle between the register bank and the
// seven-segment scan driver.
interface seg_scan_ctrl_if #(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned PWM_BITS   = 4
) ();

   logic [8*NUM_DIGITS-1:0] dig_data;
   logic [NUM_DIGITS-1:0]   dig_dot;
   logic [NUM_DIGITS-1:0]   dig_ena;
   logic [NUM_DIGITS-1:0]   dig_blink;
   logic                    raw_mode;
   logic [PWM_BITS-1:0]     brightness;
   logic                    cfg_load;
   logic                    load_busy;
   logic                    frame_done;

   modport master (
      output dig_data, dig_dot, dig_ena, dig_blink, raw_mode, brightness, cfg_load,
      input  load_busy, frame_done
   );

   modport slave (
      input  dig_data, dig_dot, dig_ena, dig_blink, raw_mode, brightness, cfg_load,
      output load_busy, frame_done
   );

endinterface

// File: rtl/seg_hex_font.sv
// Combinational 4-bit hex to seven-segment {g..a} decoder, active high.
module seg_hex_font
   import seg_pkg::*;
(
   input  logic [3:0]        nibble,
   output logic [FONT_W-1:0] segs
);

   assign segs = hex_font(nibble);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed N-digit seven-segment scan driver with blink, PWM dimming,
// an anti-ghosting blank interval and frame-synchronous shadow loading.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned SCAN_DIV     = 50000,
   parameter int unsigned BLANK_CYC    = 16,
   parameter int unsigned BLINK_FRAMES = 25,
   parameter int unsigned PWM_BITS     = 4,
   parameter bit          SEG_ACT_LOW  = 1'b1,
   parameter bit          CS_ACT_LOW   = 1'b1,
   localparam int unsigned DIG_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                  clk,
   input  logic                  RSTn,
   seg_scan_ctrl_if.slave        cfg,
   output logic [SEG_W-1:0]      seg_o,
   output logic [NUM_DIGITS-1:0] segcs_o,
   output logic [DIG_W-1:0]      cur_digit
);

   localparam int unsigned SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned BLK_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
   localparam logic [SLOT_W-1:0] BLANK_LAST = SLOT_W'(BLANK_CYC - 1);
   localparam logic [DIG_W-1:0]  DIG_LAST   = DIG_W'(NUM_DIGITS - 1);
   localparam logic [BLK_W-1:0]  BLK_LAST   = BLK_W'(BLINK_FRAMES - 1);

   slot_state_e                      state_q, state_n;
   logic [SLOT_W-1:0]                slot_cnt;
   logic [PWM_BITS-1:0]              pwm_cnt;
   logic [BLK_W-1:0]                 blink_cnt;
   logic                             blink_phase;
   logic                             busy_q;
   logic                             frame_done_q;

   logic [NUM_DIGITS-1:0][SEG_W-1:0] sh_data;
   logic [NUM_DIGITS-1:0]            sh_dot;
   logic [NUM_DIGITS-1:0]            sh_ena;
   logic [NUM_DIGITS-1:0]            sh_blink;
   logic                             sh_raw;
   logic [PWM_BITS-1:0]              sh_bright;

   logic                             slot_wrap_c;
   logic                             frame_wrap_c;
   logic                             pwm_open_c;
   logic                             lit_c;
   logic [SEG_W-1:0]                 cur_data_c;
   logic [SEG_W-1:0]                 seg_c;
   logic [FONT_W-1:0]                font_c;
   logic [NUM_DIGITS-1:0]            cs_c;

   assign slot_wrap_c    = (slot_cnt == SLOT_LAST);
   assign frame_wrap_c   = slot_wrap_c && (cur_digit == DIG_LAST);
   assign cur_data_c     = sh_data[cur_digit];
   assign cfg.load_busy  = busy_q;
   assign cfg.frame_done = frame_done_q;

   seg_hex_font u_font (
      .nibble (cur_data_c[3:0]),
      .segs   (font_c)
   );

   // Slot state register
   always_ff @(posedge clk) begin
      if (!RSTn) state_q <= ST_BLANK;
      else       state_q <= state_n;
   end

   // Slot FSM next state, segment decode and select gating
   always_comb begin
      state_n    = state_q;
      seg_c      = '0;
      cs_c       = '0;
      pwm_open_c = (sh_bright == '1) || (pwm_cnt < sh_bright);
      lit_c      = 1'b0;

      case (state_q)
         ST_BLANK: if (slot_cnt == BLANK_LAST) state_n = ST_DRIVE;
         ST_DRIVE: if (slot_wrap_c)            state_n = ST_BLANK;
         default:                              state_n = ST_BLANK;
      endcase

      if (sh_raw) begin
         seg_c = cur_data_c;
      end else begin
         seg_c[SEG_G:SEG_A] = font_c;
         seg_c[SEG_DP]      = sh_dot[cur_digit];
      end

      lit_c = (state_q == ST_DRIVE) && sh_ena[cur_digit] &&
              !(sh_blink[cur_digit] && blink_phase) && pwm_open_c;
      if (lit_c) cs_c[cur_digit] = 1'b1;
   end

   // Scan, PWM and blink timebases
   always_ff @(posedge clk) begin
      if (!RSTn) begin
         slot_cnt    <= '0;
         cur_digit   <= '0;
         pwm_cnt     <= '0;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else begin
         slot_cnt <= slot_wrap_c ? '0 : slot_cnt + SLOT_W'(1);
         if (slot_wrap_c) begin
            cur_digit <= (cur_digit == DIG_LAST) ? '0 : cur_digit + DIG_W'(1);
         end
         pwm_cnt <= ((state_q == ST_DRIVE) && !slot_wrap_c) ? pwm_cnt + PWM_BITS'(1) : '0;
         if (frame_wrap_c) begin
            if (blink_cnt == BLK_LAST) begin
               blink_cnt   <= '0;
               blink_phase <= !blink_phase;
            end else begin
               blink_cnt <= blink_cnt + BLK_W'(1);
            end
         end
      end
   end

   // Load request is held until the frame boundary, where the shadow set updates atomically
   always_ff @(posedge clk) begin
      if (!RSTn) begin
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         sh_data      <= '0;
         sh_dot       <= '0;
         sh_ena       <= '0;
         sh_blink     <= '0;
         sh_raw       <= 1'b0;
         sh_bright    <= '0;
      end else begin
         frame_done_q <= frame_wrap_c;
         if (frame_wrap_c) begin
            busy_q <= 1'b0;
            if (busy_q || cfg.cfg_load) begin
               sh_data   <= cfg.dig_data;
               sh_dot    <= cfg.dig_dot;
               sh_ena    <= cfg.dig_ena;
               sh_blink  <= cfg.dig_blink;
               sh_raw    <= cfg.raw_mode;
               sh_bright <= cfg.brightness;
            end
         end else if (cfg.cfg_load) begin
            busy_q <= 1'b1;
         end
      end
   end

   // Pin drivers with configurable polarity
   always_ff @(posedge clk) begin
      if (!RSTn) begin
         seg_o   <= {SEG_W{SEG_ACT_LOW}};
         segcs_o <= {NUM_DIGITS{CS_ACT_LOW}};
      end else begin
         seg_o   <= seg_c ^ {SEG_W{SEG_ACT_LOW}};
         segcs_o <= cs_c ^ {NUM_DIGITS{CS_ACT_LOW}};
      end
   end

endmodule
